// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store bus controller for the MW stage.
// Accepts one memory request at a time and runs a req/ack transaction on the
// data bus. It stalls the pipeline via lsu_busy while the access is
// outstanding, then returns a one-cycle rsp_valid with extended load data.
// Misaligned or unsupported accesses complete without a bus cycle. A bus
// that never acks is abandoned after TIMEOUT cycles.
module lsu_bus_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        lsu_busy,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign,
   output logic        timeout,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       funct3_reg;
   logic [1:0]       lane_reg;

   logic        f3_legal;
   logic        aligned;
   logic        req_ok;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;

   // Legality: loads allow LB/LH/LW/LBU/LHU, stores only SB/SH/SW;
   // alignment depends on the access size in funct3[1:0].
   always_comb begin
      f3_legal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = !req_we;
         default:                f3_legal = 1'b0;
      endcase
      aligned = 1'b1;
      case (req_funct3[1:0])
         2'b01:   aligned = !req_addr[0];
         2'b10:   aligned = (req_addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      req_ok = f3_legal && aligned;
   end

   // Per-lane byte enable and replicated store data. Each byte lane picks
   // its enable and source byte from the access size and the address.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign be_next[gi] = (req_funct3[1:0] == 2'b00) ? (req_addr[1:0] == LANE) :
                              (req_funct3[1:0] == 2'b01) ? (req_addr[1] == LANE[1]) :
                              1'b1;
         assign wdata_next[8*gi +: 8] = (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                                        (req_funct3[1:0] == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                        req_wdata[8*gi +: 8];
      end
   endgenerate

   // Load extraction from the acked bus word using the latched lane/funct3.
   always_comb begin
      load_byte = 8'h00;
      case (lane_reg)
         2'd0:    load_byte = bus_rdata[7:0];
         2'd1:    load_byte = bus_rdata[15:8];
         2'd2:    load_byte = bus_rdata[23:16];
         default: load_byte = bus_rdata[31:24];
      endcase
      load_half = lane_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      load_data = bus_rdata;
      case (funct3_reg)
         3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
         3'b001:  load_data = {{16{load_half[15]}}, load_half};
         3'b100:  load_data = {24'h000000, load_byte};
         3'b101:  load_data = {16'h0000, load_half};
         default: load_data = bus_rdata;
      endcase
   end

   // Stall while a request is being accepted or the bus access is pending.
   // Held low during reset so a reset cycle never stalls the pipeline.
   assign lsu_busy = !reset && (((state_reg == IDLE) && req_valid) || (state_reg == ACCESS));

   // Controller FSM with registered bus and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         funct3_reg <= 3'b000;
         lane_reg   <= 2'b00;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'h0;
         bus_be     <= 4'h0;
         bus_wdata  <= 32'h0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'h0;
         misalign   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         // Response outputs are single-cycle pulses unless set below.
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         misalign  <= 1'b0;
         timeout   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  funct3_reg <= req_funct3;
                  lane_reg   <= req_addr[1:0];
                  bus_addr   <= {req_addr[31:2], 2'b00};
                  bus_be     <= be_next;
                  bus_wdata  <= wdata_next;
                  cnt_reg    <= '0;
                  if (req_ok) begin
                     state_reg <= ACCESS;
                     bus_req   <= 1'b1;
                     bus_we    <= req_we;
                  end else begin
                     state_reg <= RESP;
                     rsp_valid <= 1'b1;
                     misalign  <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // An ack in the same cycle as the wait limit takes priority.
               if (bus_ack) begin
                  state_reg <= RESP;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= bus_we ? 32'h0 : load_data;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= RESP;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  timeout   <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Testbench for lsu_bus_ctrl: directed vectors with a response scoreboard.
module tb_lsu_bus_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        lsu_busy;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        misalign;
   logic        timeout;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   lsu_bus_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .lsu_busy(lsu_busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .misalign(misalign), .timeout(timeout),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int          exp_cyc;
      logic [31:0] rdata;
      logic        mis;
      logic        to;
      string       name;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_k;     // cycle of ack, 0 = never ack
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] bwdata;
      logic [31:0] exp_rdata;
      logic        to;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every rsp_valid pops the oldest expected response.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && rsp_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected rsp_valid at cycle %0d: rdata 0x%08h, none expected", cyc, rsp_rdata);
         end else begin
            e = sb.pop_front();
            check({e.name, " rsp cycle"}, 32'(cyc), 32'(e.exp_cyc));
            check({e.name, " rsp_rdata"}, rsp_rdata, e.rdata);
            check({e.name, " misalign"}, {31'h0, misalign}, {31'h0, e.mis});
            check({e.name, " timeout"}, {31'h0, timeout}, {31'h0, e.to});
            $display("rsp %-10s cyc=%0d rdata=0x%08h misalign=%0b timeout=%0b",
                     e.name, cyc, rsp_rdata, misalign, timeout);
         end
      end
   end

   // Issue one request and check the bus side cycle by cycle.
   task automatic run_vec(input vec_t v);
      int t0;
      int last;
      exp_t e;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      t0 = cyc;
      #1 check({v.name, " busy c0"}, {31'h0, lsu_busy}, 32'h1);
      last = v.mis ? 0 : ((v.ack_k != 0) ? v.ack_k : TO);
      e.exp_cyc = t0 + last + 1;
      e.rdata   = v.exp_rdata;
      e.mis     = v.mis;
      e.to      = v.to;
      e.name    = v.name;
      sb.push_back(e);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         check({v.name, " bus_req"}, {31'h0, bus_req}, 32'h1);
         check({v.name, " busy"}, {31'h0, lsu_busy}, 32'h1);
         if (c == 1) begin
            check({v.name, " bus_be"}, {28'h0, bus_be}, {28'h0, v.be});
            check({v.name, " bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
            check({v.name, " bus_we"}, {31'h0, bus_we}, {31'h0, v.we});
            if (v.we) check({v.name, " bus_wdata"}, bus_wdata, v.bwdata);
         end
         if (c == v.ack_k) begin
            bus_ack   = 1'b1;
            bus_rdata = v.rdata;
         end else begin
            bus_ack   = 1'b0;
            bus_rdata = 32'h5A5A5A5A;
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      bus_ack   = 1'b0;
      check({v.name, " bus_req off"}, {31'h0, bus_req}, 32'h0);
      check({v.name, " busy off"}, {31'h0, lsu_busy}, 32'h0);
   endtask

   vec_t vecs[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset state, with req_valid held high to show busy is gated.
      check("reset lsu_busy", {31'h0, lsu_busy}, 32'h0);
      check("reset bus_req", {31'h0, bus_req}, 32'h0);
      check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("reset flags", {30'h0, misalign, timeout}, 32'h0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset bus_be/we", {27'h0, bus_we, bus_be}, 32'h0);
      check("reset bus_addr", bus_addr, 32'h0);
      check("reset bus_wdata", bus_wdata, 32'h0);
      req_valid = 1'b0;
      reset = 1'b0;

      //              name         we  f3      addr          wdata         ack rdata         mis  be      bwdata        exp_rdata     to
      vecs.push_back('{"LW100",    0, 3'b010, 32'h00000100, 32'h0,        1, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0});
      vecs.push_back('{"LB103",    0, 3'b000, 32'h00000103, 32'h0,        2, 32'h80112233, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0});
      vecs.push_back('{"LBU103",   0, 3'b100, 32'h00000103, 32'h0,        1, 32'h80112233, 0, 4'b1000, 32'h0,        32'h00000080, 0});
      vecs.push_back('{"SH102",    1, 3'b001, 32'h00000102, 32'h0000ABCD, 1, 32'h12345678, 0, 4'b1100, 32'hABCDABCD, 32'h0,        0});
      vecs.push_back('{"LW101",    0, 3'b010, 32'h00000101, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        0});
      vecs.push_back('{"F3_011",   0, 3'b011, 32'h00000104, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        0});
      vecs.push_back('{"LW_TO",    0, 3'b010, 32'h00000108, 32'h0,        0, 32'h0,        0, 4'b1111, 32'h0,        32'h0,        1});
      vecs.push_back('{"LW_ACK4",  0, 3'b010, 32'h00000108, 32'h0,        4, 32'h0BADF00D, 0, 4'b1111, 32'h0,        32'h0BADF00D, 0});
      vecs.push_back('{"LH102",    0, 3'b001, 32'h00000102, 32'h0,        3, 32'h80011234, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0});
      vecs.push_back('{"SB101",    1, 3'b000, 32'h00000101, 32'h000000A5, 2, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h0,        0});
      vecs.push_back('{"LHU100",   0, 3'b101, 32'h00000100, 32'h0,        1, 32'h1234F00D, 0, 4'b0011, 32'h0,        32'h0000F00D, 0});
      vecs.push_back('{"SW10C",    1, 3'b010, 32'h0000010C, 32'hCAFEF00D, 1, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0,        0});
      vecs.push_back('{"SH101",    1, 3'b001, 32'h00000101, 32'h00001111, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        0});
      vecs.push_back('{"S_F3_100", 1, 3'b100, 32'h00000100, 32'h00000022, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        0});

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset in cycle 2 of a wait: transaction abandoned, late ack ignored.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00000200;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_mid bus_req c1", {31'h0, bus_req}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      #1 check("rst_mid busy in reset", {31'h0, lsu_busy}, 32'h0);
      @(negedge clk);
      check("rst_mid bus_req c3", {31'h0, bus_req}, 32'h0);
      reset = 1'b0;
      bus_ack = 1'b1;
      bus_rdata = 32'h77777777;
      #1 check("rst_mid busy c3", {31'h0, lsu_busy}, 32'h0);
      @(negedge clk);
      bus_ack = 1'b0;
      check("rst_mid no rsp c4", {31'h0, rsp_valid}, 32'h0);
      check("rst_mid bus_req c4", {31'h0, bus_req}, 32'h0);
      $display("txn rst_mid abandoned at cycle %0d", cyc);

      // Requests accepted again from IDLE after the abandoned one.
      run_vec('{"LW_POST", 0, 3'b010, 32'h00000300, 32'h0, 1, 32'h13572468, 0, 4'b1111, 32'h0, 32'h13572468, 0});
      run_vec('{"LB_POST", 0, 3'b000, 32'h00000301, 32'h0, 1, 32'h0000_7F00, 0, 4'b0010, 32'h0, 32'h0000007F, 0});

      repeat (3) @(negedge clk);
      check("scoreboard drained", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_bus_ctrl.md
# lsu_bus_ctrl

Load/store bus controller for the MW stage of the 3-stage RISC-V core. It takes the memory request of the instruction in MW and runs a req/ack transaction on the data bus. While the access is outstanding it holds the pipeline via `lsu_busy`. It returns a one-cycle `rsp_valid` with sign/zero-extended load data, which is the valid/stall source consumed by the forwarding/stall/flush logic. It also generates byte enables and replicated store data, and detects misaligned or unsupported accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 255: maximum ACCESS cycles without `bus_ack` before abort; legal range ≥1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: MW instruction is a load/store.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign field.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low-aligned.
- `lsu_busy` out 1: stall request to the pipeline.
- `rsp_valid` out 1: one-cycle completion pulse, for every request.
- `rsp_rdata` out 32: extended load data; 0 for stores, errors and timeouts.
- `misalign` out 1: pulse with `rsp_valid` on a misaligned access or unsupported funct3.
- `timeout` out 1: pulse with `rsp_valid` on a bus timeout.
- `bus_req` out 1: bus request, level.
- `bus_we` out 1: write strobe.
- `bus_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: transfer complete; `bus_rdata` is valid in the same cycle.
- `bus_rdata` in 32: read word.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, `req_valid`=0: no action.
- IDLE, `req_valid`=1: latch we, funct3, addr and wdata. `lsu_busy`=1 combinationally in this cycle.
  - Legal and aligned: go to ACCESS and clear the wait counter.
  - Otherwise: go to RESP with the misalign flag set; no bus cycle is issued.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Alignment rules: halfword requires `addr[0]`=0; word requires `addr[1:0]`=0.
- ACCESS drives `bus_req`=1 with `bus_addr`/`bus_we`/`bus_be`/`bus_wdata` from the latched values. They stay stable until ack or timeout. `lsu_busy`=1.
- ACCESS with `bus_ack`=1: capture the extended `bus_rdata` (loads) into `rsp_rdata` and go to RESP.
- ACCESS without ack: increment the counter. If the counter equals TIMEOUT-1, go to RESP with the timeout flag set.
- ACCESS ack and timeout limit in the same cycle: ack wins, no timeout.
- RESP: `rsp_valid`=1, flags valid, `lsu_busy`=0 so MW advances at this edge. `req_valid` is ignored. Always return to IDLE.
- Byte enables:
  - byte: `bus_be` = 1<<`addr[1:0]`.
  - half: `addr[1]` ? 1100 : 0011.
  - word: 1111.
  - The same enables apply to loads.
- Store data: SB = `{4{wdata[7:0]}}`, SH = `{2{wdata[15:0]}}`, SW = `wdata`.
- Load extraction: select the byte at `addr[1:0]` or the half at `addr[1]` from `bus_rdata`. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW is passed through.
- Counter width is `$clog2(TIMEOUT+1)`. No wrap is possible, because the counter is cleared on ACCESS entry.

## Timing
- Reset values: state IDLE, counter 0, and `bus_req`, `rsp_valid`, `misalign`, `timeout`, `rsp_rdata`, `bus_be`, `bus_we`, `bus_addr`, `bus_wdata` all 0. `lsu_busy` is 0 during reset.
- Request accepted at cycle 0. `bus_req` is high from cycle 1. Ack in cycle k≥1 puts `rsp_valid` in cycle k+1. `lsu_busy` is high in cycles 0..k.
- Zero-wait ack: 2-cycle stall, `rsp_valid` in cycle 2.
- Misaligned or unsupported: `lsu_busy` in cycle 0 only, `rsp_valid`+`misalign` in cycle 1, `bus_req` never asserted.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles (1..TIMEOUT). `rsp_valid`+`timeout` in cycle TIMEOUT+1.
- `bus_ack` outside ACCESS is ignored.
- Reset mid-ACCESS: at the next edge, state is IDLE and `bus_req`=0; the transaction is abandoned with no `rsp_valid`.
- Reset during RESP: the pulse is truncated and all outputs are 0 next cycle.

## Test plan
- LW at 0x100, ack in cycle 1, `bus_rdata`=0xDEADBEEF:
  - `bus_be`=1111, `bus_addr`=0x100.
  - `rsp_valid`+`rsp_rdata`=0xDEADBEEF in cycle 2.
  - `lsu_busy` high in cycles 0-1.
- LB at 0x103 with `bus_rdata`=0x80112233 → `bus_be`=1000, `rsp_rdata`=0xFFFFFF80. The same access as LBU → 0x00000080.
- SH at 0x102 with `wdata`=0x0000ABCD → `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_we`=1, `rsp_rdata`=0.
- LW at 0x101 → `misalign`+`rsp_valid` in cycle 1 with `bus_req` never high. funct3=011 at an aligned address gives the same result.
- TIMEOUT=4, no ack:
  - `bus_req` high in cycles 1-4.
  - `timeout`+`rsp_valid` in cycle 5.
  - A repeat run with ack in cycle 4 gives no timeout.
- Reset asserted in cycle 2 of a wait: `bus_req`=0 in cycle 3. An ack in cycle 3 is ignored and no `rsp_valid` follows. Back-to-back requests are accepted again from IDLE.
